// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//
// Decouples Fetch from Decode. PCs from Fetch go straight out as reads to a
// synchronous instruction memory with a one-cycle read latency. The returned
// {pc, inst} pairs are buffered in a DEPTH-entry FIFO, and Decode drains that
// FIFO through a valid/ready handshake. A flush (taken branch) discards both
// the queued entries and any read that is still in flight.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   AW     PC / instruction-address width
//   DW     instruction width
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   pc_in       PC from Fetch          pc_valid / pc_ready  Fetch handshake
//   flush       taken branch: kill queue and in-flight read
//   imem_req    memory read strobe     imem_addr  read address (= pc_in)
//   imem_rdata  read data, valid the cycle after imem_req
//   id_valid    head entry valid       id_ready   Decode accepts head
//   id_pc       head PC                id_inst    head instruction
//   count       occupied FIFO entries (the in-flight read is not counted)
//
// Configuration
//   IFQ_BYPASS_EN  When defined, a return arriving at an empty queue is shown
//                  on id_* in the same cycle (written only if Decode does not
//                  take it). When undefined, every return goes through the
//                  FIFO and imem_rdata has no combinational path to id_*.
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [AW-1:0]          pc_in,
  input  logic                   pc_valid,
  output logic                   pc_ready,
  input  logic                   flush,
  output logic                   imem_req,
  output logic [AW-1:0]          imem_addr,
  input  logic [DW-1:0]          imem_rdata,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [AW-1:0]          id_pc,
  output logic [DW-1:0]          id_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Control state
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          inflight;

  // Data state
  logic [AW-1:0] pend_pc;
  logic [AW-1:0] pc_mem   [DEPTH];
  logic [DW-1:0] inst_mem [DEPTH];
  logic [AW-1:0] last_pc;
  logic [DW-1:0] last_inst;

  logic          empty;
  logic          accept;
  logic          ret;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;

  assign empty     = (cnt == '0);
  // The in-flight read has a reserved slot, so it counts against capacity;
  // a pop happening this same cycle is deliberately not credited.
  assign occupancy = {1'b0, cnt} + (CW+1)'(inflight);
  assign pc_ready  = reset & ~flush & (occupancy < (CW+1)'(DEPTH));
  assign accept    = pc_valid & pc_ready;
  assign imem_req  = accept;
  assign imem_addr = pc_in;

  // Data returning this cycle; a flush drops it.
  assign ret = inflight & ~flush;

`ifdef IFQ_BYPASS_EN
  assign bypass   = empty & ret;
  assign id_valid = ~empty | bypass;
  always_comb begin
    id_pc   = last_pc;
    id_inst = last_inst;
    if (!empty) begin
      id_pc   = pc_mem[rd_ptr];
      id_inst = inst_mem[rd_ptr];
    end else if (bypass) begin
      id_pc   = pend_pc;
      id_inst = imem_rdata;
    end
  end
`else
  assign bypass   = 1'b0;
  assign id_valid = ~empty;
  // When empty, the last value shown to Decode is held.
  assign id_pc    = empty ? last_pc   : pc_mem[rd_ptr];
  assign id_inst  = empty ? last_inst : inst_mem[rd_ptr];
`endif

  // A bypassed return taken by Decode the same cycle never enters the FIFO;
  // a pop only moves the read pointer when the FIFO itself holds the head.
  assign push = ret & ~(bypass & id_ready);
  assign pop  = ~empty & id_ready;

  assign count = cnt;

  // Control registers: pointers, occupancy, in-flight flag, held outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      inflight  <= 1'b0;
      last_pc   <= '0;
      last_inst <= '0;
    end else begin
      if (id_valid) begin
        last_pc   <= id_pc;
        last_inst <= id_inst;
      end
      // accept is already blocked by flush, so a flush clears this too.
      inflight <= accept;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Data registers: pending PC and FIFO storage
  always_ff @(posedge clock) begin
    if (accept) pend_pc <= pc_in;
    if (push) begin
      pc_mem[wr_ptr]   <= pend_pc;
      inst_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule
